// File: rtl/mcu_sched_if.sv
// Upstream symbol channel feeding the MCU scheduler.
// The source drives the symbol fields; the scheduler returns sym_ready.
interface mcu_sched_if;
  logic       sym_valid;
  logic       sym_ready;
  logic       sym_eob;
  logic [3:0] sym_run;
  logic [9:0] sym_din;
  logic       sym_sign;
  logic [4:0] sym_size;

  modport master (
    output sym_valid, sym_eob, sym_run, sym_din, sym_sign, sym_size,
    input  sym_ready
  );

  modport slave (
    input  sym_valid, sym_eob, sym_run, sym_din, sym_sign, sym_size,
    output sym_ready
  );
endinterface

// File: rtl/mcu_sched.sv
// Walks the 4:2:0 MCUs of a frame (Y,Y,Y,Y,Cb,Cr), tracks the AC coefficient
// position of each block and turns accepted symbols into registered packer strobes.
module mcu_sched (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [11:0]   mcu_total,
  input  logic          stall,
  mcu_sched_if.slave    sym,
  output logic          den,
  output logic          eob,
  output logic          dc,
  output logic          lumenb,
  output logic          chromenb_u,
  output logic          chromenb_v,
  output logic          idle,
  output logic [9:0]    din,
  output logic          din_sign,
  output logic [4:0]    length_bit,
  output logic          flush,
  output logic          frame_done,
  output logic [2:0]    blk_idx,
  output logic [11:0]   mcu_cnt,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_DC, S_AC, S_FLUSH, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  blk_idx_reg, blk_idx_next;
  logic [11:0] mcu_cnt_reg, mcu_cnt_next;
  logic [11:0] mcu_total_reg, mcu_total_next;
  logic [6:0]  pos_reg, pos_next;
  logic        err_reg, err_next;

  logic        den_reg, den_next;
  logic        eob_reg, eob_next;
  logic        dc_reg, dc_next;
  logic [2:0]  sel_reg, sel_next;
  logic        idle_reg, idle_next;
  logic [9:0]  din_reg, din_next;
  logic        din_sign_reg, din_sign_next;
  logic [4:0]  length_bit_reg, length_bit_next;
  logic        flush_reg, flush_next;
  logic        frame_done_reg, frame_done_next;

  logic        ready;
  logic        xfer;
  logic        blk_end;
  logic [6:0]  pos_sum;
  logic [1:0]  comp;
  logic [2:0]  comp_sel;

  assign ready         = ((state_reg == S_DC) || (state_reg == S_AC)) && !stall;
  assign sym.sym_ready = ready;
  assign xfer          = sym.sym_valid && ready;
  assign pos_sum       = pos_reg + {3'b000, sym.sym_run} + 7'd1;

  // Component of the block being accepted: 0 = Y, 1 = Cb, 2 = Cr.
  assign comp = (blk_idx_reg < 3'd4) ? 2'd0 : ((blk_idx_reg == 3'd4) ? 2'd1 : 2'd2);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_comp_sel
      assign comp_sel[gi] = (comp == gi[1:0]);
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    blk_idx_next    = blk_idx_reg;
    mcu_cnt_next    = mcu_cnt_reg;
    mcu_total_next  = mcu_total_reg;
    pos_next        = pos_reg;
    err_next        = err_reg;
    blk_end         = 1'b0;
    den_next        = 1'b0;
    eob_next        = 1'b0;
    dc_next         = 1'b0;
    sel_next        = 3'b000;
    idle_next       = 1'b1;
    din_next        = din_reg;
    din_sign_next   = din_sign_reg;
    length_bit_next = length_bit_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          blk_idx_next   = 3'd0;
          mcu_cnt_next   = 12'd0;
          err_next       = 1'b0;
          pos_next       = 7'd0;
          mcu_total_next = mcu_total;
          state_next     = (mcu_total == 12'd0) ? S_FLUSH : S_DC;
        end
      end
      S_DC: begin
        if (xfer) begin
          den_next   = 1'b1;
          dc_next    = 1'b1;
          pos_next   = 7'd1;
          state_next = S_AC;
        end
      end
      S_AC: begin
        if (xfer) begin
          if (sym.sym_eob) begin
            eob_next = 1'b1;
            blk_end  = 1'b1;
          end else begin
            den_next = 1'b1;
            pos_next = pos_sum;
            // Landing exactly on 64 is a legal full block; beyond it is an overrun.
            if (pos_sum >= 7'd64) blk_end = 1'b1;
            if (pos_sum > 7'd64)  err_next = 1'b1;
          end
        end
      end
      S_FLUSH: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (xfer) begin
      idle_next       = 1'b0;
      sel_next        = comp_sel;
      din_next        = sym.sym_din;
      din_sign_next   = sym.sym_sign;
      length_bit_next = sym.sym_size;
    end

    if (blk_end) begin
      pos_next = 7'd0;
      if (blk_idx_reg < 3'd5) begin
        blk_idx_next = blk_idx_reg + 3'd1;
        state_next   = S_DC;
      end else begin
        blk_idx_next = 3'd0;
        mcu_cnt_next = mcu_cnt_reg + 12'd1;
        state_next   = (mcu_cnt_reg + 12'd1 == mcu_total_reg) ? S_FLUSH : S_DC;
      end
    end

    flush_next      = (state_next == S_FLUSH);
    frame_done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= S_IDLE;
      blk_idx_reg    <= 3'd0;
      mcu_cnt_reg    <= 12'd0;
      mcu_total_reg  <= 12'd0;
      pos_reg        <= 7'd0;
      err_reg        <= 1'b0;
      den_reg        <= 1'b0;
      eob_reg        <= 1'b0;
      dc_reg         <= 1'b0;
      sel_reg        <= 3'b000;
      idle_reg       <= 1'b1;
      din_reg        <= 10'd0;
      din_sign_reg   <= 1'b0;
      length_bit_reg <= 5'd0;
      flush_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      blk_idx_reg    <= blk_idx_next;
      mcu_cnt_reg    <= mcu_cnt_next;
      mcu_total_reg  <= mcu_total_next;
      pos_reg        <= pos_next;
      err_reg        <= err_next;
      den_reg        <= den_next;
      eob_reg        <= eob_next;
      dc_reg         <= dc_next;
      sel_reg        <= sel_next;
      idle_reg       <= idle_next;
      din_reg        <= din_next;
      din_sign_reg   <= din_sign_next;
      length_bit_reg <= length_bit_next;
      flush_reg      <= flush_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign den        = den_reg;
  assign eob        = eob_reg;
  assign dc         = dc_reg;
  assign lumenb     = sel_reg[0];
  assign chromenb_u = sel_reg[1];
  assign chromenb_v = sel_reg[2];
  assign idle       = idle_reg;
  assign din        = din_reg;
  assign din_sign   = din_sign_reg;
  assign length_bit = length_bit_reg;
  assign flush      = flush_reg;
  assign frame_done = frame_done_reg;
  assign blk_idx    = blk_idx_reg;
  assign mcu_cnt    = mcu_cnt_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_mcu_sched.sv
// Self-checking bench for mcu_sched: randomized symbol streams checked against
// a block/MCU-level model of the frame walk and coefficient positions.
module tb_mcu_sched;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [11:0] mcu_total = 12'd0;
  logic        den, eob, dc, lumenb, chromenb_u, chromenb_v, idle;
  logic [9:0]  din;
  logic        din_sign;
  logic [4:0]  length_bit;
  logic        flush, frame_done, err;
  logic [2:0]  blk_idx;
  logic [11:0] mcu_cnt;

  mcu_sched_if sif ();

  mcu_sched dut (
    .clk(clk), .nrst(nrst), .start(start), .mcu_total(mcu_total), .stall(stall),
    .sym(sif),
    .den(den), .eob(eob), .dc(dc), .lumenb(lumenb), .chromenb_u(chromenb_u),
    .chromenb_v(chromenb_v), .idle(idle), .din(din), .din_sign(din_sign),
    .length_bit(length_bit), .flush(flush), .frame_done(frame_done),
    .blk_idx(blk_idx), .mcu_cnt(mcu_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: current block (0..5), MCU index, coefficient position, sticky overrun.
  int   mb, mm, mpos;
  logic merr;

  task automatic idle_cycle();
    sif.sym_valid = 1'b0;
    stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (idle !== 1'b1 || den !== 1'b0 || eob !== 1'b0 || dc !== 1'b0 ||
        {lumenb, chromenb_u, chromenb_v} !== 3'b000) begin
      errors++;
      $display("FAIL gap_idle: idle=%0b den=%0b eob=%0b dc=%0b sel=%03b, required idle=1 rest 0",
               idle, den, eob, dc, {lumenb, chromenb_u, chromenb_v});
    end
  endtask

  task automatic send_sym(input bit is_dc, input bit eob_f, input logic [3:0] run,
                          input logic [4:0] sz, input int force_stall, input int stall_pct,
                          output bit blk_end);
    logic [9:0] d;
    logic       s;
    logic [2:0] exp_sel;
    bit         e_den, e_eob, e_dc, got;
    int         pre_b, np, cyc;
    d = 10'($urandom);
    s = 1'($urandom);
    pre_b = mb;
    blk_end = 1'b0;
    if (is_dc) begin
      e_den = 1; e_eob = 0; e_dc = 1; mpos = 1;
    end else if (eob_f) begin
      e_den = 0; e_eob = 1; e_dc = 0; blk_end = 1'b1;
    end else begin
      e_den = 1; e_eob = 0; e_dc = 0;
      np = mpos + int'(run) + 1;
      if (np > 64) merr = 1'b1;
      if (np >= 64) blk_end = 1'b1;
      mpos = np;
    end
    if (blk_end) begin
      if (mb < 5) mb++;
      else begin mb = 0; mm++; end
    end
    exp_sel = (pre_b < 4) ? 3'b100 : ((pre_b == 4) ? 3'b010 : 3'b001);

    sif.sym_valid = 1'b1;
    sif.sym_eob   = eob_f;
    sif.sym_run   = run;
    sif.sym_din   = d;
    sif.sym_sign  = s;
    sif.sym_size  = sz;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 64) begin
      stall = (cyc < force_stall) || ($urandom_range(0, 99) < stall_pct);
      @(negedge clk);
      checks++;
      if (sif.sym_ready !== !stall) begin
        errors++;
        $display("FAIL sym_ready: got %0b, required %0b (stall=%0b)", sif.sym_ready, !stall, stall);
      end
      got = (sif.sym_ready === 1'b1);
      @(posedge clk); #1;
      if (!got) begin
        checks++;
        if (idle !== 1'b1 || den !== 1'b0 || eob !== 1'b0 || dc !== 1'b0 ||
            {lumenb, chromenb_u, chromenb_v} !== 3'b000) begin
          errors++;
          $display("FAIL stall_idle: idle=%0b den=%0b eob=%0b dc=%0b, required idle=1 den=eob=dc=0",
                   idle, den, eob, dc);
        end
      end
      cyc++;
    end
    sif.sym_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL xfer_timeout: no transfer within 64 cycles, required one");
      return;
    end
    if (den !== e_den || eob !== e_eob || dc !== e_dc || idle !== 1'b0) begin
      errors++;
      $display("FAIL strobes: den=%0b eob=%0b dc=%0b idle=%0b, required den=%0b eob=%0b dc=%0b idle=0",
               den, eob, dc, idle, e_den, e_eob, e_dc);
    end
    checks++;
    if ({lumenb, chromenb_u, chromenb_v} !== exp_sel) begin
      errors++;
      $display("FAIL selects: got %03b, required %03b (block %0d)",
               {lumenb, chromenb_u, chromenb_v}, exp_sel, pre_b);
    end
    checks++;
    if (din !== d || din_sign !== s || length_bit !== sz) begin
      errors++;
      $display("FAIL fields: din=%0d sign=%0b len=%0d, required din=%0d sign=%0b len=%0d",
               din, din_sign, length_bit, d, s, sz);
    end
    checks++;
    if (blk_idx !== 3'(mb) || mcu_cnt !== 12'(mm) || err !== merr) begin
      errors++;
      $display("FAIL position: blk_idx=%0d mcu_cnt=%0d err=%0b, required blk_idx=%0d mcu_cnt=%0d err=%0b",
               blk_idx, mcu_cnt, err, mb, mm, merr);
    end
    $display("xfer mcu=%0d blk=%0d dc=%0b eob=%0b run=%0d pos=%0d end=%0b",
             mm, pre_b, is_dc, eob_f, run, mpos, blk_end);
  endtask

  // mode 0 random AC, 1 = 63 run-0 symbols, 2 = overrun from pos 50, 3 = DC + EOB
  task automatic send_block(input int mode, input int stall_pct);
    bit          e;
    logic [3:0]  seq [5];
    send_sym(1'b1, 1'($urandom), 4'($urandom), 5'($urandom), 0, stall_pct, e);
    case (mode)
      1: while (!e) send_sym(1'b0, 1'b0, 4'd0, 5'($urandom_range(1, 10)), 0, stall_pct, e);
      2: begin
        seq = '{4'd15, 4'd15, 4'd15, 4'd0, 4'd15};
        for (int i = 0; i < 5; i++)
          send_sym(1'b0, 1'b0, seq[i], (i == 4) ? 5'd0 : 5'd3, 0, stall_pct, e);
      end
      3: send_sym(1'b0, 1'b1, 4'd0, 5'd31, 0, stall_pct, e);
      default: while (!e) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        if ($urandom_range(0, 4) == 0)
          send_sym(1'b0, 1'b1, 4'd0, 5'd31, 0, stall_pct, e);
        else
          send_sym(1'b0, 1'b0, 4'($urandom_range(0, 15)), 5'($urandom_range(1, 10)), 0, stall_pct, e);
      end
    endcase
  endtask

  task automatic do_start(input int total);
    mb = 0; mm = 0; mpos = 0; merr = 1'b0;
    mcu_total = 12'(total);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_frame_end();
    checks++;
    if (flush !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL flush: flush=%0b frame_done=%0b, required 1/0", flush, frame_done);
    end
    @(posedge clk); #1;
    checks++;
    if (flush !== 1'b0 || frame_done !== 1'b1 || den !== 1'b0) begin
      errors++;
      $display("FAIL frame_done: flush=%0b frame_done=%0b den=%0b, required 0/1/0", flush, frame_done, den);
    end
    @(posedge clk); #1;
    checks++;
    if (flush !== 1'b0 || frame_done !== 1'b0 || sif.sym_ready !== 1'b0) begin
      errors++;
      $display("FAIL back_idle: flush=%0b frame_done=%0b ready=%0b, required all 0",
               flush, frame_done, sif.sym_ready);
    end
  endtask

  task automatic send_frame(input int total, input int mode0, input int mode, input int stall_pct);
    do_start(total);
    for (int mi = 0; mi < total; mi++)
      for (int bi = 0; bi < 6; bi++)
        send_block((mi == 0 && bi == 0) ? mode0 : mode, stall_pct);
    if (total == 0) begin
      checks++;
      if (den !== 1'b0) begin
        errors++;
        $display("FAIL empty_den: den=%0b, required 0", den);
      end
    end
    check_frame_end();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (den !== 0 || eob !== 0 || dc !== 0 || idle !== 1 || flush !== 0 || frame_done !== 0 ||
        {lumenb, chromenb_u, chromenb_v} !== 3'b000 || blk_idx !== 0 || mcu_cnt !== 0 ||
        err !== 0 || din !== 0 || length_bit !== 0 || sif.sym_ready !== 0) begin
      errors++;
      $display("FAIL reset: den=%0b eob=%0b dc=%0b idle=%0b blk=%0d mcu=%0d err=%0b ready=%0b, required idle=1 rest 0",
               den, eob, dc, idle, blk_idx, mcu_cnt, err, sif.sym_ready);
    end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_mcu();
    send_frame(1, 3, 3, 0);
  endtask

  task automatic test_full_block();
    send_frame(1, 1, 3, 0);
  endtask

  task automatic test_overrun();
    send_frame(1, 2, 3, 0);
  endtask

  task automatic test_stall();
    bit e;
    do_start(1);
    send_sym(1'b1, 1'b0, 4'd0, 5'd4, 5, 0, e);
    send_sym(1'b0, 1'b0, 4'd2, 5'd3, 5, 0, e);
    send_sym(1'b0, 1'b1, 4'd0, 5'd31, 0, 0, e);
    for (int bi = 1; bi < 6; bi++) send_block(3, 0);
    check_frame_end();
  endtask

  task automatic test_empty_frame();
    send_frame(0, 3, 3, 0);
  endtask

  task automatic test_reset_mid();
    bit e;
    do_start(2);
    for (int bi = 0; bi < 4; bi++) send_block(3, 0);
    send_sym(1'b1, 1'b0, 4'd0, 5'd5, 0, 0, e);
    send_sym(1'b0, 1'b0, 4'd0, 5'd6, 0, 0, e);
    send_sym(1'b0, 1'b0, 4'd1, 5'd7, 0, 0, e);
    nrst = 1'b0;
    #1;
    checks++;
    if (den !== 0 || idle !== 1 || {lumenb, chromenb_u, chromenb_v} !== 3'b000 ||
        blk_idx !== 0 || mcu_cnt !== 0 || err !== 0 || sif.sym_ready !== 0) begin
      errors++;
      $display("FAIL reset_mid: den=%0b idle=%0b blk=%0d mcu=%0d ready=%0b, required 0/1/0/0/0",
               den, idle, blk_idx, mcu_cnt, sif.sym_ready);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    send_frame(1, 3, 3, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++)
      send_frame($urandom_range(1, 3), 0, 0, 30);
  endtask

  task automatic test_back_to_back();
    send_frame(2, 0, 0, 0);
  endtask

  initial begin
    sif.sym_valid = 1'b0;
    sif.sym_eob   = 1'b0;
    sif.sym_run   = 4'd0;
    sif.sym_din   = 10'd0;
    sif.sym_sign  = 1'b0;
    sif.sym_size  = 5'd0;
    test_reset();
    test_single_mcu();
    test_full_block();
    test_overrun();
    test_stall();
    test_empty_frame();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at 900000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mcu_sched.md
MCU_SCHED -- requirements
Module: mcu_sched

Interface
REQ-001 clk  in  1  clock; all state on rising edge.
REQ-002 nrst  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  frame start pulse; sampled only in IDLE.
REQ-004 mcu_total  in  12  number of 4:2:0 MCUs in the frame; latched on accepted start.
REQ-005 stall  in  1  downstream word FIFO almost-full; blocks symbol acceptance.
REQ-006 sym_valid / sym_ready  in / out  1 / 1  upstream symbol handshake; transfer on valid&ready.
REQ-007 sym_eob  in  1  current AC symbol is EOB (0x00).
REQ-008 sym_run  in  4  AC zero-run preceding the coefficient (15 with size 0 = ZRL).
REQ-009 sym_din / sym_sign / sym_size  in  10 / 1 / 5  amplitude bits, sign, bit size (31 = no amplitude).
REQ-010 den / eob / dc  out  1 / 1 / 1  registered packer strobes.
REQ-011 lumenb / chromenb_u / chromenb_v  out  1 each  registered component select, one-hot or all zero.
REQ-012 idle  out  1  registered; high in every cycle in which no symbol is issued.
REQ-013 din / din_sign / length_bit  out  10 / 1 / 5  registered copies of the accepted symbol fields.
REQ-014 flush / frame_done  out  1 / 1  single-cycle pulses at frame end.
REQ-015 blk_idx / mcu_cnt  out  3 / 12  current block in MCU (0..5) and MCU index.
REQ-016 err  out  1  sticky: AC position overrun.

Function
REQ-017 FSM states: IDLE, DC, AC, FLUSH, DONE.
REQ-018 IDLE->DC on start, clearing blk_idx, mcu_cnt, err; if mcu_total==0, IDLE->FLUSH instead.
REQ-019 sym_ready = (state==DC or AC) & ~stall, purely combinational; it does not depend on sym_valid.
REQ-020 Block order per MCU: blk_idx 0-3 luma, 4 Cb, 5 Cr; component selects derive from blk_idx of the accepted symbol.
REQ-021 Each output strobe appears exactly one cycle after its transfer; the cycle without a transfer has den=eob=dc=0, idle=1, and all selects 0.
REQ-022 DC transfer: den=1, dc=1, eob=0; sym_eob is ignored; pos set to 1; DC->AC.
REQ-023 AC non-EOB transfer: den=1, dc=0; pos_next = pos + sym_run + 1 (7-bit).
REQ-024 AC EOB transfer: den=0, eob=1, dc=0; block ends.
REQ-025 Block also ends when pos_next == 64 (last coefficient nonzero, no EOB emitted).
REQ-026 pos_next > 64: set err, end block, and issue the symbol as a normal AC symbol.
REQ-027 Block end: if blk_idx<5 then blk_idx+1 and ->DC; else blk_idx=0 and mcu_cnt+1; if mcu_cnt==mcu_total-1 ->FLUSH, else ->DC.
REQ-028 FLUSH: one-cycle flush=1, then ->DONE; DONE: one-cycle frame_done=1, then ->IDLE.
REQ-029 start outside IDLE is ignored; stall freezes all state except the output pipeline register, which issues idle=1.

Reset
REQ-030 nrst low: state=IDLE; all outputs 0 except idle=1; blk_idx=0, mcu_cnt=0, pos=0, err=0; takes effect immediately, including mid-block.

Verification
REQ-031 mcu_total=1, each block DC + EOB -> 12 transfers; selects Y,Y,Y,Y,U,V; flush one cycle after the last EOB, then frame_done.
REQ-032 Block of DC + 63 run-0 AC symbols, no EOB -> block ends on the 63rd AC symbol; next symbol carries dc=1; err=0.
REQ-033 AC run=15 size 0 after pos=50 -> pos_next=66, err=1, block advances.
REQ-034 stall=1 for 5 cycles with sym_valid high -> sym_ready=0, idle=1 for 5 cycles, no transfer lost or duplicated.
REQ-035 mcu_total=0 with start -> flush the next cycle, frame_done the cycle after; no den issued.
REQ-036 nrst asserted mid-AC at blk_idx=4 -> outputs return to reset values at once; a new start begins at blk_idx=0 with dc=1.
